// File: rtl/switch_pulse_sequencer.sv
// Timing sequencer for the photonic switch drivers.
// A prescaler produces base ticks, ticks are grouped into frames of SLOTS slots,
// and each channel emits a programmable-width pulse on its slot or on every tick.
// Channel configuration is shadowed and only changes at frame boundaries.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | sequencer stopped, counters hold, running pulses may finish
//  RUN   | prescaler/slot/frame counters advance, channels may fire
module switch_pulse_sequencer #(
   parameter  int DIV   = 25,
   parameter  int SLOTS = 8,
   parameter  int NCH   = 2,
   parameter  int PW_W  = 4,
   parameter  int FC_W  = 8,
   localparam int DW    = $clog2(DIV),
   localparam int SW    = $clog2(SLOTS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  abort,
   input  logic                  one_shot,
   input  logic [FC_W-1:0]       n_frames,
   input  logic [NCH*SW-1:0]     ch_slot,
   input  logic [NCH-1:0]        ch_every,
   input  logic [NCH*PW_W-1:0]   ch_len,
   output logic [NCH-1:0]        ch_out,
   output logic                  frame_tick,
   output logic [SW-1:0]         slot_idx,
   output logic [FC_W-1:0]       frame_cnt,
   output logic                  busy
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [DW-1:0]   PRE_LAST  = DW'(DIV - 1);
   localparam logic [SW-1:0]   SLOT_LAST = SW'(SLOTS - 1);
   localparam logic [FC_W:0]   ONE_FC    = (FC_W+1)'(1);

   state_t                state, state_nxt;
   logic                  stop_pending;
   logic [DW-1:0]         pre_cnt;
   logic [NCH*SW-1:0]     sh_slot;
   logic [NCH-1:0]        sh_every;
   logic [NCH*PW_W-1:0]   sh_len;
   logic                  sh_one_shot;
   logic [FC_W-1:0]       sh_n_frames;
   logic [PW_W-1:0]       pulse_cnt [NCH];
   logic [NCH-1:0]        fire;

   logic                  run_act, tick, frame_end, start_go, burst_done;
   logic [FC_W:0]         n_eff, frames_next;

   // Abort wins over everything; a start that coincides with stop/abort is dropped.
   assign run_act     = (state == RUN) && !abort;
   assign tick        = run_act && en && (pre_cnt == PRE_LAST);
   assign frame_end   = tick && (slot_idx == SLOT_LAST);
   assign start_go    = (state == IDLE) && start && !stop && !abort;
   assign n_eff       = (sh_n_frames == '0) ? ONE_FC : {1'b0, sh_n_frames};
   assign frames_next = {1'b0, frame_cnt} + ONE_FC;
   assign burst_done  = sh_one_shot && (frames_next == n_eff);
   assign busy        = (state == RUN);

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic: run until abort or a frame end that finishes the run.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (start_go) state_nxt = RUN;
         RUN: begin
            if (abort)                                        state_nxt = IDLE;
            else if (frame_end && (stop_pending || burst_done)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Graceful-stop request is held until the run actually ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                   stop_pending <= 1'b0;
      else if (state == RUN && state_nxt == IDLE)   stop_pending <= 1'b0;
      else if (state == RUN && stop)                stop_pending <= 1'b1;
   end

   // Prescaler, slot and frame counters; they hold whenever en is low or idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt   <= '0;
         slot_idx  <= '0;
         frame_cnt <= '0;
      end else if (start_go) begin
         pre_cnt   <= '0;
         slot_idx  <= '0;
         frame_cnt <= '0;
      end else if (run_act && en) begin
         pre_cnt <= tick ? '0 : pre_cnt + DW'(1);
         if (tick)      slot_idx  <= (slot_idx == SLOT_LAST) ? '0 : slot_idx + SW'(1);
         if (frame_end) frame_cnt <= frame_cnt + FC_W'(1);
      end
   end

   // Frame strobe lags the last tick of the frame by one clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) frame_tick <= 1'b0;
      else        frame_tick <= frame_end;
   end

   // Shadow config: channel fields reload at start and every frame boundary;
   // burst mode is captured only at start so a run cannot change its own length.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sh_slot     <= '0;
         sh_every    <= '0;
         sh_len      <= '0;
         sh_one_shot <= 1'b0;
         sh_n_frames <= '0;
      end else begin
         if (start_go || frame_end) begin
            sh_slot  <= ch_slot;
            sh_every <= ch_every;
            sh_len   <= ch_len;
         end
         if (start_go) begin
            sh_one_shot <= one_shot;
            sh_n_frames <= n_frames;
         end
      end
   end

   // Per-channel fire decision; a zero length disables the channel.
   always_comb begin
      fire = '0;
      for (int i = 0; i < NCH; i++) begin
         fire[i] = tick && (sh_len[i*PW_W +: PW_W] != '0) &&
                   (sh_every[i] || (sh_slot[i*SW +: SW] == slot_idx));
      end
   end

   // Pulse down-counters: load on fire (restarting any live pulse), otherwise
   // count down to terminal zero independent of en; abort kills them at once.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NCH; i++) pulse_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (abort)                    pulse_cnt[i] <= '0;
            else if (fire[i])             pulse_cnt[i] <= sh_len[i*PW_W +: PW_W];
            else if (pulse_cnt[i] != '0)  pulse_cnt[i] <= pulse_cnt[i] - PW_W'(1);
         end
      end
   end

   // A channel is high while its counter has not reached terminal count.
   always_comb begin
      ch_out = '0;
      for (int i = 0; i < NCH; i++) ch_out[i] = (pulse_cnt[i] != '0);
   end

endmodule
